sync_fifo_prog: RTL and testbench

Single-clock, parametrised FIFO. It extends the team's dual-clock FIFO with several additions: a fill-level output, programmable almost-full and almost-empty thresholds, an optional first-word-fall-through (FWFT) read mode, a synchronous clear, and sticky overflow/underflow error flags. It is used as the intra-domain buffer between pipeline stages and as the landing buffer behind CDC FIFOs.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_mem.sv | 36 +++
 rtl/sync_fifo_prog.sv | 134 +++++++++++++
 tb/tb_sync_fifo_prog.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry, read-mode selectors and a
// width helper. Used by the single-clock and dual-clock FIFOs.
package fifo_pkg;

    localparam int unsigned FIFO_DEFAULT_DATA_WIDTH    = 8;
    localparam int unsigned FIFO_DEFAULT_ADDRESS_WIDTH = 4;
    localparam int unsigned FIFO_DEFAULT_DEPTH         = 1 << FIFO_DEFAULT_ADDRESS_WIDTH;

    // Read-mode selectors for the FWFT parameter.
    localparam int unsigned FIFO_MODE_STD  = 0;
    localparam int unsigned FIFO_MODE_FWFT = 1;

    // Number of bits needed to encode values 0..value-1 (minimum 1).
    function automatic int unsigned fifo_clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((32'd1 << width) < value) begin
            width = width + 1;
        end
        return (width == 0) ? 1 : width;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x DATA_WIDTH register array, one synchronous write
// port and one asynchronous read port. Contents are not reset.
// Ports:
//   clk        - write clock, rising edge
//   write_en   - write strobe
//   write_addr - write address
//   write_data - write data
//   read_addr  - read address
//   read_data  - combinational read data
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = FIFO_DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = FIFO_DEFAULT_ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     write_en,
    input  logic [ADDRESS_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic [ADDRESS_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0]    read_data
);

    localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
    end

    assign read_data = mem[read_addr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with fill level, programmable almost-full/almost-empty
// thresholds, optional first-word-fall-through read, synchronous clear and
// sticky overflow/underflow flags.
// Ports:
//   clk, reset_n              - clock (rising edge), async active-low reset
//   clear                     - synchronous flush (wins over write/read)
//   write_enable, data_in     - write request and data
//   fifo_full, almost_full    - level == DEPTH, level >= ALMOST_FULL_LEVEL
//   read_enable, data_out     - read request (pop in FWFT mode) and data
//   fifo_empty, almost_empty  - level == 0, level <= ALMOST_EMPTY_LEVEL
//   fifo_level                - stored word count, 0..DEPTH
//   overflow, underflow       - sticky error flags
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH         = FIFO_DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH      = FIFO_DEFAULT_ADDRESS_WIDTH,
    parameter int unsigned ALMOST_FULL_LEVEL  = 12,
    parameter int unsigned ALMOST_EMPTY_LEVEL = 2,
    parameter int unsigned FWFT               = FIFO_MODE_STD
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   write_enable,
    input  logic [DATA_WIDTH-1:0]  data_in,
    output logic                   fifo_full,
    output logic                   almost_full,
    input  logic                   read_enable,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   fifo_empty,
    output logic                   almost_empty,
    output logic [ADDRESS_WIDTH:0] fifo_level,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;
    localparam int unsigned LW    = ADDRESS_WIDTH + 1;

    localparam logic [ADDRESS_WIDTH:0] DEPTH_LVL = LW'(DEPTH);
    localparam logic [ADDRESS_WIDTH:0] AF_LVL    = LW'(ALMOST_FULL_LEVEL);
    localparam logic [ADDRESS_WIDTH:0] AE_LVL    = LW'(ALMOST_EMPTY_LEVEL);

    logic [ADDRESS_WIDTH:0]  wr_ptr;
    logic [ADDRESS_WIDTH:0]  rd_ptr;
    logic [ADDRESS_WIDTH:0]  level_q;
    logic                    overflow_q;
    logic                    underflow_q;
    logic                    wr_accept;
    logic                    rd_accept;
    logic [DATA_WIDTH-1:0]   mem_rd_data;

    // Status is decoded from the registered level only.
    assign fifo_full    = (level_q == DEPTH_LVL);
    assign fifo_empty   = (level_q == '0);
    assign almost_full  = (level_q >= AF_LVL);
    assign almost_empty = (level_q <= AE_LVL);
    assign fifo_level   = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_accept = write_enable & ~fifo_full  & ~clear;
    assign rd_accept = read_enable  & ~fifo_empty & ~clear;

    fifo_mem #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_mem (
        .clk        (clk),
        .write_en   (wr_accept),
        .write_addr (wr_ptr[ADDRESS_WIDTH-1:0]),
        .write_data (data_in),
        .read_addr  (rd_ptr[ADDRESS_WIDTH-1:0]),
        .read_data  (mem_rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_accept, rd_accept})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            if (write_enable && fifo_full) begin
                overflow_q <= 1'b1;
            end
            if (read_enable && fifo_empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            // Head word is presented directly; forced to zero while empty so
            // reset/clear leave data_out at 0 as in the registered mode.
            assign data_out = fifo_empty ? '0 : mem_rd_data;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] data_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    data_q <= '0;
                end else if (clear) begin
                    data_q <= '0;
                end else if (rd_accept) begin
                    data_q <= mem_rd_data;
                end
            end

            assign data_out = data_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
module tb_sync_fifo_prog;

    logic       clk;
    logic       reset_n;
    logic       clear;
    logic       write_enable;
    logic       read_enable;
    logic [7:0] data_in;

    logic       fifo_full, almost_full, fifo_empty, almost_empty, overflow, underflow;
    logic [7:0] data_out;
    logic [4:0] fifo_level;

    logic       fw_full, fw_afull, fw_empty, fw_aempty, fw_ovf, fw_udf;
    logic [7:0] fw_data_out;
    logic [4:0] fw_level;

    logic       af_full, af_afull, af_empty, af_aempty, af_ovf, af_udf;
    logic [7:0] af_data_out;
    logic [4:0] af_level;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;

    sync_fifo_prog #(
        .DATA_WIDTH(8), .ADDRESS_WIDTH(4), .ALMOST_FULL_LEVEL(12),
        .ALMOST_EMPTY_LEVEL(2), .FWFT(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .write_enable(write_enable), .data_in(data_in),
        .fifo_full(fifo_full), .almost_full(almost_full),
        .read_enable(read_enable), .data_out(data_out),
        .fifo_empty(fifo_empty), .almost_empty(almost_empty),
        .fifo_level(fifo_level), .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_prog #(
        .DATA_WIDTH(8), .ADDRESS_WIDTH(4), .ALMOST_FULL_LEVEL(12),
        .ALMOST_EMPTY_LEVEL(2), .FWFT(1)
    ) dut_fw (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .write_enable(write_enable), .data_in(data_in),
        .fifo_full(fw_full), .almost_full(fw_afull),
        .read_enable(read_enable), .data_out(fw_data_out),
        .fifo_empty(fw_empty), .almost_empty(fw_aempty),
        .fifo_level(fw_level), .overflow(fw_ovf), .underflow(fw_udf)
    );

    sync_fifo_prog #(
        .DATA_WIDTH(8), .ADDRESS_WIDTH(4), .ALMOST_FULL_LEVEL(16),
        .ALMOST_EMPTY_LEVEL(2), .FWFT(0)
    ) dut_af16 (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .write_enable(write_enable), .data_in(data_in),
        .fifo_full(af_full), .almost_full(af_afull),
        .read_enable(read_enable), .data_out(af_data_out),
        .fifo_empty(af_empty), .almost_empty(af_aempty),
        .fifo_level(af_level), .overflow(af_ovf), .underflow(af_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; the reference queue is advanced after the edge
    // and any read data due at this edge is queued for the monitor.
    task automatic cyc(input logic we, input logic re, input logic clr, input logic [7:0] din);
        logic was_full, was_empty;
        write_enable = we;
        read_enable  = re;
        clear        = clr;
        data_in      = din;
        was_full     = (m_q.size() == 16);
        was_empty    = (m_q.size() == 0);
        @(posedge clk);
        #1;
        if (clr) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (we && was_full)  m_ovf = 1'b1;
            if (re && was_empty) m_udf = 1'b1;
            if (re && !was_empty) exp_q.push_back(m_q.pop_front());
            if (we && !was_full)  m_q.push_back(din);
        end
        write_enable = 1'b0;
        read_enable  = 1'b0;
        clear        = 1'b0;
    endtask

    // Monitor: checks read data whenever a read result is due, plus status.
    always @(negedge clk) begin
        if (reset_n) begin
            if (exp_q.size() > 0) begin
                check("rd_data", 32'(data_out), 32'(exp_q.pop_front()));
            end
            check("level", 32'(fifo_level), 32'(m_q.size()));
            check("empty", 32'(fifo_empty), 32'(m_q.size() == 0));
            check("full", 32'(fifo_full), 32'(m_q.size() == 16));
            check("ovf", 32'(overflow), 32'(m_ovf));
            check("udf", 32'(underflow), 32'(m_udf));
            check("af16_afull", 32'(af_afull), 32'(m_q.size() == 16));
            check("fw_empty", 32'(fw_empty), 32'(m_q.size() == 0));
            if (m_q.size() > 0) begin
                check("fw_head", 32'(fw_data_out), 32'(m_q[0]));
            end
        end
    end

    initial begin
        reset_n      = 1'b0;
        clear        = 1'b0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        data_in      = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_empty", 32'(fifo_empty), 32'd1);
        check("rst_aempty", 32'(almost_empty), 32'd1);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_afull", 32'(almost_full), 32'd0);
        check("rst_flags", 32'({overflow, underflow}), 32'd0);
        check("rst_dout", 32'(data_out), 32'd0);
        reset_n = 1'b1;

        // Fill; almost_full rises after the 12th write.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'(i));
            if (i == 10) check("afull_at11", 32'(almost_full), 32'd0);
            if (i == 11) check("afull_at12", 32'(almost_full), 32'd1);
        end
        check("fill_full", 32'(fifo_full), 32'd1);
        check("fill_level", 32'(fifo_level), 32'd16);

        // Overflow: 0xAA dropped.
        cyc(1'b1, 1'b0, 1'b0, 8'hAA);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_level", 32'(fifo_level), 32'd16);

        // Drain 0x00..0x0F (monitor checks order), then underflow.
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
        check("drain_empty", 32'(fifo_empty), 32'd1);
        check("drain_last", 32'(data_out), 32'h0F);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        check("udf_set", 32'(underflow), 32'd1);
        check("udf_hold", 32'(data_out), 32'h0F);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        check("clr_flags", 32'({overflow, underflow}), 32'd0);
        check("clr_level", 32'(fifo_level), 32'd0);
        check("clr_dout", 32'(data_out), 32'd0);

        // Threshold edges.
        cyc(1'b1, 1'b0, 1'b0, 8'h20);
        cyc(1'b1, 1'b0, 1'b0, 8'h21);
        check("aempty_at2", 32'(almost_empty), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 8'h22);
        check("aempty_at3", 32'(almost_empty), 32'd0);
        for (int i = 3; i < 11; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
        check("thr_afull_at11", 32'(almost_full), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 8'h2B);
        check("thr_afull_at12", 32'(almost_full), 32'd1);
        check("af16_at12", 32'(af_afull), 32'd0);
        for (int i = 12; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
        check("af16_at16", 32'(af_afull), 32'd1);
        check("af16_full", 32'(af_full), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);

        // Simultaneous read/write at level 5 across pointer wrap.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 8'(8'h40 + i));
            check("sim_level", 32'(fifo_level), 32'd5);
            check("sim_aempty", 32'(almost_empty), 32'd0);
        end
        cyc(1'b0, 1'b0, 1'b1, 8'h00);

        // FWFT: word appears without a read, pop empties.
        cyc(1'b1, 1'b0, 1'b0, 8'h5C);
        check("fwft_dout", 32'(fw_data_out), 32'h5C);
        check("fwft_nempty", 32'(fw_empty), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        check("fwft_pop_empty", 32'(fw_empty), 32'd1);

        // Asynchronous reset between edges with 7 words stored.
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
        #2 reset_n = 1'b0;
        #1;
        m_q.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        check("arst_level", 32'(fifo_level), 32'd0);
        check("arst_empty", 32'(fifo_empty), 32'd1);
        check("arst_aempty", 32'(almost_empty), 32'd1);
        check("arst_afull", 32'({fifo_full, almost_full}), 32'd0);
        check("arst_dout", 32'(data_out), 32'd0);
        check("arst_fw_dout", 32'(fw_data_out), 32'd0);
        #3 reset_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 8'h71);
        check("post_rst_write", 32'(fifo_level), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 8'h72);
        cyc(1'b1, 1'b0, 1'b0, 8'h73);

        // Clear beats same-cycle write and read.
        cyc(1'b1, 1'b1, 1'b1, 8'hEE);
        check("clrprio_level", 32'(fifo_level), 32'd0);
        check("clrprio_flags", 32'({overflow, underflow}), 32'd0);
        check("clrprio_dout", 32'(data_out), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
